// File: rtl/ula_nibble_seq.sv
// Runs one wide 74181-style ALU operation through a single 4-bit slice, LSB nibble first,
// chaining the registered slice carry into the next nibble and returning the assembled result.
module ula_nibble_seq #(
  parameter int N_NIBBLES = 4,
  localparam int W = 4 * N_NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  // Handshake rule (both sides): a transfer happens on a rising edge where valid and ready
  // are both high; valid holds its payload until that edge, ready never waits on valid.
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   op_s,
  input  logic         op_m,
  input  logic         op_c_in,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_c_in,
  input  logic [3:0]   alu_f,
  input  logic         alu_c_out,
  input  logic         alu_a_eq_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res_f,
  output logic         res_c_out,
  output logic         res_a_eq_b,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int IW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           eq_acc;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [3:0]     s_reg;
  logic           m_reg;
  logic           last_nib;
  logic [IW+1:0]  nib_lsb;

  assign last_nib = (idx == LAST_IDX);
  assign nib_lsb  = {idx, 2'b00};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EXEC;
      EXEC:    if (last_nib) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The slice sees only registered operands; all slice inputs are parked at 0 outside EXEC.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    alu_s     = 4'd0;
    alu_m     = 1'b0;
    alu_c_in  = 1'b0;
    if (state == EXEC) begin
      alu_a    = a_reg[nib_lsb +: 4];
      alu_b    = b_reg[nib_lsb +: 4];
      alu_s    = s_reg;
      alu_m    = m_reg;
      alu_c_in = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      eq_acc     <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= 4'd0;
      m_reg      <= 1'b0;
      res_f      <= '0;
      res_c_out  <= 1'b0;
      res_a_eq_b <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            s_reg  <= op_s;
            m_reg  <= op_m;
            carry  <= op_c_in;
            idx    <= '0;
            eq_acc <= 1'b1;
          end
        end
        EXEC: begin
          // Carry is chained unmodified in both modes; in logic mode it is simply unused.
          res_f[nib_lsb +: 4] <= alu_f;
          carry               <= alu_c_out;
          eq_acc              <= eq_acc & alu_a_eq_b;
          if (last_nib) begin
            res_c_out  <= alu_c_out;
            res_a_eq_b <= eq_acc & alu_a_eq_b;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Bench for ula_nibble_seq: an ALU stub closes the slice loop, a transaction-level model
// predicts every cycle, and directed operations pin the model with literal results.
module tb_ula_nibble_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   op_s = 4'd0;
  logic         op_m = 1'b0;
  logic         op_c_in = 1'b0;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_c_in, alu_c_out, alu_a_eq_b;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res_f;
  logic         res_c_out, res_a_eq_b, busy;
  logic [1:0]   dbg_state;

  // Stub configuration: tab_mode=1 makes the slice return table-driven carry/equality keyed by alu_a.
  logic         tab_mode = 1'b0;
  logic [15:0]  ctab = 16'h0000;
  logic [15:0]  etab = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  ula_nibble_seq #(.N_NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_c_in(op_c_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_f(res_f), .res_c_out(res_c_out), .res_a_eq_b(res_a_eq_b),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] stub(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] s, input logic m, input logic c,
                                      input logic tmode, input logic [15:0] ct,
                                      input logic [15:0] et);
    logic [3:0] f;
    logic       co, eq;
    logic [4:0] sum;
    f = 4'd0; co = 1'b0; eq = 1'b0; sum = 5'd0;
    if (tmode) begin
      f = a ^ b; co = ct[a]; eq = et[a];
    end else if (m) begin
      case (s)
        4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;  4'h3: f = 4'h0;
        4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;   4'h7: f = a & ~b;
        4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;       4'hB: f = a & b;
        4'hC: f = 4'hF;      4'hD: f = a | ~b;    4'hE: f = a | b;   default: f = a;
      endcase
      co = c; eq = (f == 4'hF);
    end else begin
      sum = {1'b0, a} + {1'b0, b} + {4'b0, c};
      f = sum[3:0]; co = sum[4]; eq = (f == 4'hF);
    end
    return {eq, co, f};
  endfunction

  assign {alu_a_eq_b, alu_c_out, alu_f} = stub(alu_a, alu_b, alu_s, alu_m, alu_c_in,
                                               tab_mode, ctab, etab);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: phase 0 idle, 1 running (m_k nibbles done), 2 holding a result.
  logic [W+1:0] exp_q[$];
  int           m_phase = 0;
  int           m_k = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [3:0]   m_s = 4'd0;
  logic         m_m = 1'b0;
  logic [N-1:0] m_cin = '0;
  logic [W-1:0] exp_res_f = '0;
  logic         exp_c = 1'b0, exp_eq = 1'b0;
  logic         started = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] f;
    logic         c, eq;
    logic [5:0]   r;
    logic [W+1:0] top;
    started = 1'b1;
    if (rst) begin
      m_phase = 0; exp_res_f = '0; exp_c = 1'b0; exp_eq = 1'b0; exp_q.delete();
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_a = op_a; m_b = op_b; m_s = op_s; m_m = op_m;
        c = op_c_in; eq = 1'b1; f = '0;
        for (int i = 0; i < N; i++) begin
          m_cin[i] = c;
          r = stub(op_a[4*i +: 4], op_b[4*i +: 4], op_s, op_m, c, tab_mode, ctab, etab);
          f[4*i +: 4] = r[3:0]; c = r[4]; eq = eq & r[5];
        end
        exp_q.push_back({eq, c, f});
        m_k = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_k++;
      if (m_k == N) begin
        m_phase = 2;
        if (exp_q.size() > 0) begin
          top = exp_q.pop_front();
          {exp_eq, exp_c, exp_res_f} = top;
        end
      end
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, m_phase != 0);
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 1) begin
        chk("alu_a", alu_a, m_a[4*m_k +: 4]);
        chk("alu_b", alu_b, m_b[4*m_k +: 4]);
        chk("alu_s_m", {alu_s, alu_m}, {m_s, m_m});
        chk("alu_c_in", alu_c_in, m_cin[m_k]);
      end else begin
        chk("alu_idle", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 14'd0);
        chk("res_f", res_f, exp_res_f);
        chk("res_c_eq", {res_c_out, res_a_eq_b}, {exp_c, exp_eq});
      end
    end
  end

  logic [3:0] obs_a[64];
  logic       obs_cin[64];
  int         obs_lat;

  // Issue one op, record the per-cycle slice drive until out_valid, hold `hold` cycles, then take it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                       input logic m, input logic c, input int hold);
    int guard;
    @(negedge clk);
    op_a = a; op_b = b; op_s = s; op_m = m; op_c_in = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    obs_lat = 0;
    while (obs_lat < 50) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      obs_a[obs_lat] = alu_a; obs_cin[obs_lat] = alu_c_in;
      obs_lat++;
    end
    if (!out_valid) chk("done_timeout", 1'b0, 1'b1);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      op_a = W'($urandom_range(0, 65535)); op_b = W'($urandom_range(0, 65535));
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held_f;
    // Reset held two edges with a request pending.
    in_valid = 1'b1; op_a = 16'h1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_f", res_f, 16'h0000);
    chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 14'd0);
    rst = 1'b0; in_valid = 1'b0;

    // Logic XOR through the ALU model.
    do_op(16'hA5F0, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 0);
    chk("xor_lat", obs_lat, 4);
    chk("xor_alu_a_seq", {obs_a[0], obs_a[1], obs_a[2], obs_a[3]}, 16'h0F5A);
    chk("xor_res", res_f, 16'hAA00);

    // Arithmetic add with rippling carries.
    do_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 0);
    chk("add_res", {res_c_out, res_f}, 17'h02233);
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0);
    chk("add_wrap", {res_c_out, res_f}, 17'h10000);
    do_op(16'h7FFF, 16'h0000, 4'b1001, 1'b0, 1'b1, 0);
    chk("add_cin", {res_c_out, res_f}, 17'h08000);

    // Table stub: carry out only on nibble 0.
    tab_mode = 1'b1; ctab = 16'h0001; etab = 16'hFFFF;
    do_op(16'h3210, 16'h0000, 4'h0, 1'b0, 1'b1, 0);
    chk("cin_seq", {obs_cin[0], obs_cin[1], obs_cin[2], obs_cin[3]}, 4'b1100);
    chk("cout_last", res_c_out, 1'b0);
    chk("eq_all", res_a_eq_b, 1'b1);
    etab = 16'hFFFB;
    do_op(16'h3210, 16'h0000, 4'h0, 1'b0, 1'b0, 0);
    chk("eq_nib2", res_a_eq_b, 1'b0);

    // Backpressure: five stalled cycles with in_valid pulsing, then a back-to-back op.
    tab_mode = 1'b0;
    do_op(16'hC3C3, 16'h5A5A, 4'b0110, 1'b1, 1'b0, 5);
    chk("bp_idle_after", in_ready, 1'b1);
    held_f = res_f;
    chk("bp_res", held_f, 16'h9999);
    do_op(16'h00FF, 16'hFF00, 4'b1110, 1'b1, 1'b0, 0);
    chk("bp_next", res_f, 16'hFFFF);

    // Abort mid-operation when idx reaches 2.
    @(negedge clk);
    op_a = 16'h4321; op_b = 16'h1111; op_s = 4'b1001; op_m = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("abort_res_f", res_f, 16'h0000);
    chk("abort_state", {busy, out_valid, in_ready}, 3'b001);
    do_op(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b0, 0);
    chk("after_abort", res_f, 16'h5432);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
